// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencing controller: states, opcodes and the
// datapath select encodings.
package mc_pkg;

   typedef enum logic [3:0] {
      StFetch,
      StDecode,
      StMemAdr,
      StMemRead,
      StMemWb,
      StMemWrite,
      StExecR,
      StExecI,
      StAluWb,
      StBranch,
      StJal,
      StHalt
   } state_e;

   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;

   localparam logic [2:0] AluAdd = 3'b000;
   localparam logic [2:0] AluSub = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;
   localparam logic [2:0] AluXor = 3'b100;
   localparam logic [2:0] AluSlt = 3'b101;

   localparam logic [1:0] AluOpAdd    = 2'b00;
   localparam logic [1:0] AluOpSub    = 2'b01;
   localparam logic [1:0] AluOpDecode = 2'b10;

   localparam logic [1:0] ResAluOut    = 2'b00;
   localparam logic [1:0] ResReadData  = 2'b01;
   localparam logic [1:0] ResAluResult = 2'b10;

   localparam logic [1:0] SrcAPc    = 2'b00;
   localparam logic [1:0] SrcAOldPc = 2'b01;
   localparam logic [1:0] SrcARs1   = 2'b10;

   localparam logic [1:0] SrcBRs2  = 2'b00;
   localparam logic [1:0] SrcBImm  = 2'b01;
   localparam logic [1:0] SrcBFour = 2'b10;

   localparam logic [1:0] ImmI = 2'b00;
   localparam logic [1:0] ImmS = 2'b01;
   localparam logic [1:0] ImmB = 2'b10;
   localparam logic [1:0] ImmJ = 2'b11;

   function automatic logic [1:0] imm_sel(input logic [6:0] op);
      logic [1:0] sel;
      sel = ImmI;
      case (op)
         OpLoad, OpImm: sel = ImmI;
         OpStore:       sel = ImmS;
         OpBranch:      sel = ImmB;
         OpJal:         sel = ImmJ;
         default:       sel = 2'b00;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction fields onto the ALU control code.
module mc_alu_decoder
   import mc_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       op_b5,
   output logic [2:0] alu_control
);

   always_comb begin
      alu_control = AluAdd;
      case (alu_op)
         AluOpAdd: alu_control = AluAdd;
         AluOpSub: alu_control = AluSub;
         AluOpDecode: begin
            case (funct3)
               // Only R-type (opcode bit 5 set) may select sub; addi ignores bit 30.
               3'b000:  alu_control = (op_b5 && funct7b5) ? AluSub : AluAdd;
               3'b010:  alu_control = AluSlt;
               3'b100:  alu_control = AluXor;
               3'b110:  alu_control = AluOr;
               3'b111:  alu_control = AluAnd;
               default: alu_control = AluAdd;
            endcase
         end
         default: alu_control = AluAdd;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core. Define MC_ILLEGAL_TRAP_EN to halt on unknown
// opcodes and expose illegal_instr; otherwise unknown opcodes retire as NOPs.
module multicycle_controller
   import mc_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr,
   input  logic        zero,
   input  logic        sign_res,
   input  logic        mem_ready,
`ifdef MC_ILLEGAL_TRAP_EN
   output logic        illegal_instr,
`endif
   output logic        pc_write,
   output logic        adr_src,
   output logic        mem_write,
   output logic        ir_write,
   output logic [1:0]  result_src,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_control,
   output logic [1:0]  imm_src,
   output logic        reg_write,
   output logic        instr_retired
);

   state_e     state_q, state_d;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7b5;
   logic [1:0] alu_op;
   logic       taken;
   logic       known_op;
   logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, retire_c;
   logic       unused_instr;

   assign opcode       = instr[6:0];
   assign funct3       = instr[14:12];
   assign funct7b5     = instr[30];
   assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

   assign known_op = (opcode == OpLoad) || (opcode == OpStore) || (opcode == OpR) ||
                     (opcode == OpImm) || (opcode == OpBranch) || (opcode == OpJal);

   always_comb begin
      case (funct3)
         3'b000:  taken = zero;
         3'b001:  taken = ~zero;
         3'b100:  taken = sign_res;
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StFetch:    if (mem_ready) state_d = StDecode;
         StDecode: begin
            case (opcode)
               OpLoad, OpStore: state_d = StMemAdr;
               OpR:             state_d = StExecR;
               OpImm:           state_d = StExecI;
               OpBranch:        state_d = StBranch;
               OpJal:           state_d = StJal;
`ifdef MC_ILLEGAL_TRAP_EN
               default:         state_d = StHalt;
`else
               default:         state_d = StFetch;
`endif
            endcase
         end
         StMemAdr:   state_d = (opcode == OpLoad) ? StMemRead : StMemWrite;
         StMemRead:  if (mem_ready) state_d = StMemWb;
         StMemWrite: if (mem_ready) state_d = StFetch;
         StMemWb:    state_d = StFetch;
         StExecR:    state_d = StAluWb;
         StExecI:    state_d = StAluWb;
         StAluWb:    state_d = StFetch;
         StBranch:   state_d = StFetch;
         StJal:      state_d = StAluWb;
         StHalt:     state_d = StHalt;
         default:    state_d = StFetch;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      pc_write_c  = 1'b0;
      adr_src     = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      result_src  = ResAluOut;
      alu_src_a   = SrcAPc;
      alu_src_b   = SrcBRs2;
      alu_op      = AluOpAdd;
      reg_write_c = 1'b0;
      retire_c    = 1'b0;
      unique case (state_q)
         StFetch: begin
            alu_src_b  = SrcBFour;
            result_src = ResAluResult;
            pc_write_c = mem_ready;
            ir_write_c = mem_ready;
         end
         StDecode: begin
            // ALUOut captures the branch target while the opcode is decoded.
            alu_src_a = SrcAOldPc;
            alu_src_b = SrcBImm;
`ifndef MC_ILLEGAL_TRAP_EN
            retire_c  = ~known_op;
`endif
         end
         StMemAdr: begin
            alu_src_a = SrcARs1;
            alu_src_b = SrcBImm;
         end
         StMemRead: begin
            adr_src = 1'b1;
         end
         StMemWrite: begin
            adr_src     = 1'b1;
            mem_write_c = 1'b1;
            retire_c    = mem_ready;
         end
         StMemWb: begin
            result_src  = ResReadData;
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         StExecR: begin
            alu_src_a = SrcARs1;
            alu_op    = AluOpDecode;
         end
         StExecI: begin
            alu_src_a = SrcARs1;
            alu_src_b = SrcBImm;
            alu_op    = AluOpDecode;
         end
         StAluWb: begin
            reg_write_c = 1'b1;
            retire_c    = 1'b1;
         end
         StBranch: begin
            alu_src_a  = SrcARs1;
            alu_op     = AluOpSub;
            pc_write_c = taken;
            retire_c   = 1'b1;
         end
         StJal: begin
            alu_src_a  = SrcAOldPc;
            alu_src_b  = SrcBFour;
            pc_write_c = 1'b1;
         end
         StHalt: begin
         end
         default: begin
         end
      endcase
   end

   mc_alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op_b5       (opcode[5]),
      .alu_control (alu_control)
   );

   assign imm_src = imm_sel(opcode);

   // Enables are gated by rst_n so a mid-instruction reset has no side effects at all.
   assign pc_write      = rst_n & pc_write_c;
   assign mem_write     = rst_n & mem_write_c;
   assign ir_write      = rst_n & ir_write_c;
   assign reg_write     = rst_n & reg_write_c;
   assign instr_retired = rst_n & retire_c;

`ifdef MC_ILLEGAL_TRAP_EN
   assign illegal_instr = (state_q == StHalt);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed table-driven bench for multicycle_controller, plus reset and illegal-opcode sequences.
module tb_multicycle_controller;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instr;
   logic        zero, sign_res, mem_ready;
   logic        pc_write, adr_src, mem_write, ir_write, reg_write, instr_retired;
   logic [1:0]  result_src, alu_src_a, alu_src_b, imm_src;
   logic [2:0]  alu_control;
`ifdef MC_ILLEGAL_TRAP_EN
   logic        illegal_instr;
`endif

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .instr         (instr),
      .zero          (zero),
      .sign_res      (sign_res),
      .mem_ready     (mem_ready),
`ifdef MC_ILLEGAL_TRAP_EN
      .illegal_instr (illegal_instr),
`endif
      .pc_write      (pc_write),
      .adr_src       (adr_src),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .result_src    (result_src),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_control   (alu_control),
      .imm_src       (imm_src),
      .reg_write     (reg_write),
      .instr_retired (instr_retired)
   );

   // {pc_write, adr_src, mem_write, ir_write, result_src, a, b, alu_control, imm_src, reg_write, ret}
   logic [16:0] act;
   assign act = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                 alu_control, imm_src, reg_write, instr_retired};

   typedef struct {
      logic [31:0] instr;
      logic        zero;
      logic        sign_res;
      logic        mem_ready;
      logic [16:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [31:0] ILw   = 32'h00412283;
   localparam logic [31:0] ISw   = 32'h00512423;
   localparam logic [31:0] IBeq  = 32'h00208463;
   localparam logic [31:0] IBne  = 32'h00209463;
   localparam logic [31:0] IBlt  = 32'h0020C463;
   localparam logic [31:0] IBgeu = 32'h0020F463;
   localparam logic [31:0] ISub  = 32'h402081B3;
   localparam logic [31:0] IAdd  = 32'h002081B3;
   localparam logic [31:0] IAnd  = 32'h0020F1B3;
   localparam logic [31:0] IAddi = 32'h40008193;
   localparam logic [31:0] IXori = 32'h0000C193;
   localparam logic [31:0] ISlti = 32'h0000A193;
   localparam logic [31:0] IOri  = 32'h0000E193;
   localparam logic [31:0] IJal  = 32'h010000EF;
   localparam logic [31:0] IBad  = 32'h0000007F;

   function automatic logic [16:0] ev(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [2:0] alu,
                                      input logic [1:0] imm, input logic rw, input logic ret);
      return {pcw, adr, mw, irw, rs, a, b, alu, imm, rw, ret};
   endfunction

   function automatic logic [16:0] fetch_e(input logic [1:0] imm, input logic mr);
      return ev(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0, 1'b0);
   endfunction

   function automatic logic [16:0] decode_e(input logic [1:0] imm, input logic ret);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0, ret);
   endfunction

   function automatic logic [16:0] aluwb_e(input logic [1:0] imm);
      return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, imm, 1'b1, 1'b1);
   endfunction

   task automatic add(input logic [31:0] i, input logic z, input logic s, input logic mr,
                      input logic [16:0] e);
      vec_t v;
      v.instr     = i;
      v.zero      = z;
      v.sign_res  = s;
      v.mem_ready = mr;
      v.exp       = e;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [16:0] got, input logic [16:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b", name, got, want);
      end
   endtask

   // Called right after a falling edge: drive, sample mid-low-phase, then wait for next fall.
   task automatic step(input string name, input logic [31:0] i, input logic z, input logic s,
                       input logic mr, input logic [16:0] want);
      instr     = i;
      zero      = z;
      sign_res  = s;
      mem_ready = mr;
      #2;
      check(name, act, want);
      @(negedge clk);
   endtask

   task automatic add_alu(input logic [31:0] i, input logic [1:0] b, input logic [2:0] alu);
      add(i, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
      add(i, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
      add(i, 1'b0, 1'b0, 1'b1, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, b, alu, 2'b00, 1'b0, 1'b0));
      add(i, 1'b0, 1'b0, 1'b1, aluwb_e(2'b00));
   endtask

   task automatic add_branch(input logic [31:0] i, input logic z, input logic s, input logic pcw);
      add(i, z, s, 1'b1, fetch_e(2'b10, 1'b1));
      add(i, z, s, 1'b1, decode_e(2'b10, 1'b0));
      add(i, z, s, 1'b1, ev(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0, 1'b1));
   endtask

   localparam logic [16:0] ResetE = 17'b0_0_0_0_10_00_10_000_00_0_0;

   initial begin
      // lw, no stalls
      add(ILw, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
      add(ILw, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
      add(ILw, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
      add(ILw, 1'b0, 1'b0, 1'b1, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
      add(ILw, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1, 1));
      // sw, three wait cycles in MEMWRITE
      add(ISw, 1'b0, 1'b0, 1'b1, fetch_e(2'b01, 1'b1));
      add(ISw, 1'b0, 1'b0, 1'b1, decode_e(2'b01, 1'b0));
      add(ISw, 1'b0, 1'b0, 1'b1, ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 0, 0));
      for (int k = 0; k < 3; k++)
         add(ISw, 1'b0, 1'b0, 1'b0, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 0));
      add(ISw, 1'b0, 1'b0, 1'b1, ev(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0, 1));
      // beq taken after one fetch stall, then the branch flavours
      add(IBeq, 1'b1, 1'b0, 1'b0, fetch_e(2'b10, 1'b0));
      add_branch(IBeq, 1'b1, 1'b0, 1'b1);
      add_branch(IBne, 1'b1, 1'b0, 1'b0);
      add_branch(IBlt, 1'b0, 1'b1, 1'b1);
      add_branch(IBgeu, 1'b1, 1'b1, 1'b0);
      // ALU decode
      add_alu(ISub, 2'b00, 3'b001);
      add_alu(IAdd, 2'b00, 3'b000);
      add_alu(IAnd, 2'b00, 3'b010);
      add_alu(IAddi, 2'b01, 3'b000);
      add_alu(IXori, 2'b01, 3'b100);
      add_alu(ISlti, 2'b01, 3'b101);
      add_alu(IOri, 2'b01, 3'b011);
      // jal
      add(IJal, 1'b0, 1'b0, 1'b1, fetch_e(2'b11, 1'b1));
      add(IJal, 1'b0, 1'b0, 1'b1, decode_e(2'b11, 1'b0));
      add(IJal, 1'b0, 1'b0, 1'b1, ev(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 0, 0));
      add(IJal, 1'b0, 1'b0, 1'b1, aluwb_e(2'b11));

      // Reset state
      rst_n     = 1'b0;
      instr     = ILw;
      zero      = 1'b0;
      sign_res  = 1'b0;
      mem_ready = 1'b1;
      #2;
      check("reset", act, ResetE);
`ifdef MC_ILLEGAL_TRAP_EN
      check("reset_illegal", {16'b0, illegal_instr}, 17'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[k])
         step($sformatf("vec%0d", k), vecs[k].instr, vecs[k].zero, vecs[k].sign_res,
              vecs[k].mem_ready, vecs[k].exp);

      // Reset pulsed while MEMREAD is waiting for memory
      step("abort_fetch", ILw, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
      step("abort_decode", ILw, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
      step("abort_memadr", ILw, 1'b0, 1'b0, 1'b1,
           ev(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0, 0));
      instr     = ILw;
      mem_ready = 1'b0;
      #2;
      check("abort_memread", act, ev(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0));
      mem_ready = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("abort_in_reset", act, ResetE);
      @(negedge clk);
      check("abort_held", act, ResetE);
      rst_n = 1'b1;
      step("abort_refetch", IBad, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));

      // Unknown opcode
`ifdef MC_ILLEGAL_TRAP_EN
      step("bad_decode", IBad, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b0));
      for (int k = 0; k < 2; k++) begin
         #2;
         check($sformatf("halt%0d", k), act, 17'd0);
         check($sformatf("halt_illegal%0d", k), {16'b0, illegal_instr}, 17'd1);
         @(negedge clk);
      end
      rst_n = 1'b0;
      #2;
      check("halt_reset_illegal", {16'b0, illegal_instr}, 17'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step("halt_refetch", ILw, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
`else
      step("nop_decode", IBad, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b1));
      step("nop_refetch", IBad, 1'b0, 1'b0, 1'b1, fetch_e(2'b00, 1'b1));
      step("nop_decode2", IBad, 1'b0, 1'b0, 1'b1, decode_e(2'b00, 1'b1));
      step("nop_refetch2", ILw, 1'b0, 1'b0, 1'b0, fetch_e(2'b00, 1'b0));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
